// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for the multi-cycle shift sequencer.
// The master drives requests and accepts results; the slave is the sequencer.
interface shift_seq_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_dir, in_amt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_amt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer wrapped around an external 4-bit single-step
// shifter: loads a request, steps the shifter once per clock, returns result.
module shift_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_if.slave       io,
  output logic [WIDTH-1:0] sh_i,
  output logic             sh_d,
  input  logic [WIDTH-1:0] sh_o,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] data_r;
  logic             dir_r;
  logic [AMT_W-1:0] cnt_r;
  logic             load;
  logic             step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    load        = 1'b0;
    step        = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          load    = 1'b1;
          state_n = (io.in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_r == AMT_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request fields are captured only at the accept edge; the shifter
  // output is folded back only while stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
      dir_r  <= 1'b0;
      cnt_r  <= '0;
    end else if (load) begin
      data_r <= io.in_data;
      dir_r  <= io.in_dir;
      cnt_r  <= io.in_amt;
    end else if (step) begin
      data_r <= sh_o;
      cnt_r  <= cnt_r - AMT_W'(1);
    end
  end

  assign sh_i        = data_r;
  assign sh_d        = dir_r;
  assign io.out_data = data_r;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural single-step shifter
// hooked onto sh_i/sh_d/sh_o.
module tb_shift_seq;

  logic       clk;
  logic       rst;
  logic [3:0] sh_i;
  logic       sh_d;
  logic [3:0] sh_o;
  logic       busy;
  logic       corrupt;
  int         checks;
  int         errors;

  shift_seq_if #(.WIDTH(4), .AMT_W(3)) io ();

  shift_seq #(.WIDTH(4), .AMT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io),
    .sh_i (sh_i),
    .sh_d (sh_d),
    .sh_o (sh_o),
    .busy (busy)
  );

  // External zero-fill shifter; corrupt forces garbage to show sh_o is
  // ignored outside stepping.
  assign sh_o = corrupt ? 4'b1010 :
                sh_d    ? {1'b0, sh_i[3:1]} :
                          {sh_i[2:0], 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] d, input logic dir,
                     input logic [2:0] amt);
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_dir   = dir;
    io.in_amt   = amt;
    tick();
    io.in_valid = 1'b0;
  endtask

  initial begin
    int nbusy;
    logic [3:0] got;
    checks       = 0;
    errors       = 0;
    corrupt      = 1'b0;
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = 4'h0;
    io.in_dir    = 1'b0;
    io.in_amt    = 3'd0;
    io.out_ready = 1'b1;
    #3;
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", io.out_data, 0);
    chk("rst_sh_i", sh_i, 0);
    chk("rst_sh_d", sh_d, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1011 toward MSB by 1
    req(4'b1011, 1'b0, 3'd1);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", io.in_ready, 0);
    chk("t1_out_valid_early", io.out_valid, 0);
    chk("t1_sh_d", sh_d, 0);
    chk("t1_sh_i", sh_i, 4'b1011);
    tick();
    chk("t1_out_valid", io.out_valid, 1);
    chk("t1_out_data", io.out_data, 4'b0110);
    tick();
    chk("t1_idle_ready", io.in_ready, 1);
    chk("t1_idle_valid", io.out_valid, 0);

    // 1011 toward LSB by 2
    req(4'b1011, 1'b1, 3'd2);
    chk("t2_sh_i0", sh_i, 4'b1011);
    chk("t2_sh_d", sh_d, 1);
    tick();
    chk("t2_sh_i1", sh_i, 4'b0101);
    chk("t2_valid_early", io.out_valid, 0);
    tick();
    chk("t2_out_valid", io.out_valid, 1);
    chk("t2_out_data", io.out_data, 4'b0010);
    tick();

    // amount 0 goes straight to DONE; shifter output is garbage
    corrupt = 1'b1;
    req(4'b1011, 1'b0, 3'd0);
    chk("t3_out_valid", io.out_valid, 1);
    chk("t3_out_data", io.out_data, 4'b1011);
    chk("t3_busy", busy, 1);
    tick();
    chk("t3_idle", busy, 0);
    corrupt = 1'b0;

    // amount 7 on 1111: eight busy cycles, result zero
    req(4'b1111, 1'b0, 3'd7);
    nbusy = 0;
    got   = 4'hx;
    for (int i = 0; i < 20 && busy; i++) begin
      nbusy++;
      if (io.out_valid) got = io.out_data;
      tick();
    end
    chk("t4_busy_cycles", nbusy, 8);
    chk("t4_out_data", got, 4'b0000);

    // back-pressure; a pending request must not load at the handshake
    io.out_ready = 1'b0;
    req(4'b0011, 1'b0, 3'd1);
    tick();
    io.in_valid = 1'b1;
    io.in_data  = 4'b1001;
    io.in_amt   = 3'd2;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", io.out_valid, 1);
      chk("t5_hold_data", io.out_data, 4'b0110);
      chk("t5_hold_ready", io.in_ready, 0);
      tick();
    end
    io.out_ready = 1'b1;
    tick();
    chk("t5_idle_ready", io.in_ready, 1);
    chk("t5_idle_valid", io.out_valid, 0);
    chk("t5_no_load", io.out_data, 4'b0110);
    io.in_valid = 1'b0;
    tick();

    // async reset mid-SHIFT, between edges
    req(4'b1111, 1'b1, 3'd5);
    tick();
    chk("t6_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_in_ready", io.in_ready, 1);
    chk("t6_rst_out_valid", io.out_valid, 0);
    chk("t6_rst_out_data", io.out_data, 0);
    chk("t6_rst_sh_i", sh_i, 0);
    chk("t6_rst_sh_d", sh_d, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_stale_valid", io.out_valid, 0);
    req(4'b0001, 1'b0, 3'd3);
    tick();
    tick();
    chk("t6_valid_early", io.out_valid, 0);
    tick();
    chk("t6_out_valid", io.out_valid, 1);
    chk("t6_out_data", io.out_data, 4'b1000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer that sits directly around the 4-bit single-step shifter stage.
- Accepts a word, direction and shift amount over a valid/ready handshake, then drives the shifter one step per clock.
- Registers the shifter's output back each cycle and presents the final word over a valid/ready output handshake.
- The shifter itself stays external; this block owns all state.

Parameters:
- WIDTH, 4, data width; must equal the shifter width (4).
- AMT_W, 3, width of the shift-amount field (0..7 steps).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  word to shift.
- in_dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
- in_amt  input  AMT_W  number of single-bit steps.
- sh_i  output  WIDTH  to shifter inputs i3..i0; sh_i[3] = i3.
- sh_d  output  1  to shifter direction input d.
- sh_o  input  WIDTH  from shifter outputs o3..o0; sh_o[3] = o3.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Shifter contract (combinational, zero fill):
  - d=0: o = {i[2:0],0}.
  - d=1: o = {0,i[3:1]}.
- Internal registers: data_r[WIDTH], dir_r, cnt_r[AMT_W], state.
- sh_i = data_r and sh_d = dir_r continuously. out_data = data_r.
- Reset (async, rst=1), all forced immediately:
  - state=IDLE; data_r=0; dir_r=0; cnt_r=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_data=0, sh_i=0, sh_d=0.
- Reset mid-operation discards the in-flight word. No output is produced for it.
- State IDLE:
  - in_ready=1.
  - On in_valid, load data_r=in_data, dir_r=in_dir, cnt_r=in_amt.
  - If in_amt=0, next state is DONE; otherwise SHIFT.
- State SHIFT:
  - in_ready=0.
  - Each clock: data_r<=sh_o; cnt_r<=cnt_r-1.
  - When cnt_r=1 at the edge, next state is DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - Hold data_r stable while out_ready=0.
  - On out_valid&&out_ready, next state is IDLE.
- Latency: out_valid rises N+1 clocks after the accepting edge, with N=in_amt (amt=0 gives 1 clock).
- Throughput: one request per N+2 cycles minimum. There is no accept in the same cycle as an output handshake.
- Amounts above WIDTH are legal. They take the full N cycles and yield 0000.
- in_data, in_dir and in_amt are sampled only at the accept edge. Changes afterwards are ignored.
- sh_o is sampled only in SHIFT. Its value in other states is don't-care.
- in_valid while busy is ignored. The source must hold it until in_ready.

Test Plan:
- Reset then in_data=1011, dir=0, amt=1 -> out_valid after 2 clocks; out_data=0110; sh_d=0 during SHIFT.
- in_data=1011, dir=1, amt=2 -> sh_i sequence 1011,0101; out_data=0010 after 3 clocks.
- in_data=1011, amt=0 -> out_valid 1 clock after accept; out_data=1011; no SHIFT cycle; sh_o ignored.
- in_data=1111, dir=0, amt=7 -> busy 8 cycles; out_data=0000.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data held; in_ready=0. Then out_ready=1 -> IDLE next clock; in_ready=1.
- Assert rst mid-SHIFT, asynchronously between edges -> state, outputs and sh_i go to reset values immediately. After release, a new request (0001, dir=0, amt=3) -> 1000.
